rx_block_buffer: RTL and testbench

- Parametrised successor to the fixed 4x32-bit receive shift register in the AES datapath.
- Packs WORD_W-bit words arriving from the AHB master into BLOCK_W-bit cipher blocks.
- Assembled blocks go into a DEPTH-entry block FIFO, so the AHB master can keep fetching while AESctrl is still busy with the previous block.
- Adds a selectable word order, zero-padded flush of a partial final block, and a per-block last tag for the controller.

---
 rtl/rx_block_buffer.sv | 122 ++++++++++++
 tb/tb_rx_block_buffer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_block_buffer.sv
// rx_block_buffer
// Packs WORD_W-bit bus words into BLOCK_W-bit cipher blocks and queues the
// finished blocks in a DEPTH-entry show-ahead FIFO with a per-block last tag.
module rx_block_buffer #(
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int DEPTH           = 2,
    localparam int BLOCK_W        = WORD_W * WORDS_PER_BLOCK,
    localparam int LVL_W          = $clog2(DEPTH + 1),
    localparam int WH_W           = $clog2(WORDS_PER_BLOCK)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  word_in,
    input  logic               word_valid,
    output logic               word_ready,
    input  logic               word_last,
    input  logic               word_order,
    input  logic               sclr,
    output logic [BLOCK_W-1:0] block_out,
    output logic               block_last,
    output logic               block_valid,
    input  logic               block_ready,
    output logic [LVL_W-1:0]   level,
    output logic [WH_W-1:0]    words_held
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [BLOCK_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]   last_mem;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [BLOCK_W-1:0] asm_q;
    logic [BLOCK_W-1:0] asm_next;
    logic               order_q;
    logic               eff_order;
    int unsigned        slot;
    logic               accept;
    logic               complete;
    logic               pop;
    logic [LVL_W-1:0]   level_next;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign block_valid = (level != '0);
    assign block_out   = mem[rd_ptr];
    assign block_last  = last_mem[rd_ptr];

    // Word placement, block completion and next FIFO occupancy
    always_comb begin
        accept    = word_valid & word_ready & ~sclr;
        // the first word of a block uses the live order input, later words the latched one
        eff_order = (words_held == '0) ? word_order : order_q;
        slot      = eff_order ? int'(words_held)
                              : WORDS_PER_BLOCK - 1 - int'(words_held);
        // slices not yet written are zero, so OR-ing the shifted word places it
        asm_next  = asm_q | ({{(BLOCK_W - WORD_W){1'b0}}, word_in} << (slot * WORD_W));
        complete  = accept & ((words_held == WH_W'(WORDS_PER_BLOCK - 1)) | word_last);
        pop       = block_valid & block_ready & ~sclr;
        if (sclr)
            level_next = '0;
        else if (complete & ~pop)
            level_next = level + 1'b1;
        else if (pop & ~complete)
            level_next = level - 1'b1;
        else
            level_next = level;
    end

    // Assembly register, pointers, occupancy and registered ready
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_ready <= 1'b0;
            level      <= '0;
            words_held <= '0;
            asm_q      <= '0;
            order_q    <= 1'b0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
        end else begin
            word_ready <= (level_next < LVL_W'(DEPTH));
            level      <= level_next;
            if (sclr) begin
                words_held <= '0;
                asm_q      <= '0;
                rd_ptr     <= '0;
                wr_ptr     <= '0;
            end else begin
                if (accept) begin
                    if (words_held == '0)
                        order_q <= word_order;
                    if (complete) begin
                        words_held <= '0;
                        asm_q      <= '0;
                        wr_ptr     <= ptr_inc(wr_ptr);
                    end else begin
                        words_held <= words_held + 1'b1;
                        asm_q      <= asm_next;
                    end
                end
                if (pop)
                    rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    // Block storage written when a block completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            last_mem <= '0;
        end else if (complete) begin
            mem[wr_ptr]      <= asm_next;
            last_mem[wr_ptr] <= word_last;
        end
    end

endmodule

// File: tb/tb_rx_block_buffer.sv
// Self-checking bench for rx_block_buffer: queue-based reference model,
// a per-cycle compare process, and directed literal checks.
module tb_rx_block_buffer;

    localparam int WORD_W  = 32;
    localparam int WPB     = 4;
    localparam int DEPTH   = 2;
    localparam int BLOCK_W = WORD_W * WPB;
    localparam int LVL_W   = $clog2(DEPTH + 1);
    localparam int WH_W    = $clog2(WPB);

    logic               tb_clk = 1'b0;
    logic               rst;
    logic [WORD_W-1:0]  word_in;
    logic               word_valid;
    logic               word_ready;
    logic               word_last;
    logic               word_order;
    logic               sclr;
    logic [BLOCK_W-1:0] block_out;
    logic               block_last;
    logic               block_valid;
    logic               block_ready;
    logic [LVL_W-1:0]   level;
    logic [WH_W-1:0]    words_held;

    int checks   = 0;
    int failures = 0;

    // reference model state
    logic [BLOCK_W-1:0] q_data[$];
    logic               q_last[$];
    logic [WORD_W-1:0]  m_words[WPB];
    int                 m_cnt;
    logic               m_ord;
    logic               m_ready;

    rx_block_buffer #(.WORD_W(WORD_W), .WORDS_PER_BLOCK(WPB), .DEPTH(DEPTH)) dut (
        .clk(tb_clk), .rst(rst), .word_in(word_in), .word_valid(word_valid),
        .word_ready(word_ready), .word_last(word_last), .word_order(word_order),
        .sclr(sclr), .block_out(block_out), .block_last(block_last),
        .block_valid(block_valid), .block_ready(block_ready), .level(level),
        .words_held(words_held)
    );

    always #5 tb_clk = ~tb_clk;

    task automatic check(input string name, input logic [BLOCK_W-1:0] act,
                         input logic [BLOCK_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_data.delete();
        q_last.delete();
        m_cnt   = 0;
        m_ord   = 1'b0;
        m_ready = 1'b0;
    endtask

    // One clock edge of the model, using the inputs stable across that edge
    task automatic model_edge();
        logic [BLOCK_W-1:0] blk;
        logic [WORD_W-1:0]  w;
        bit                 do_pop;
        do_pop = (q_data.size() > 0) && block_ready;
        if (sclr) begin
            q_data.delete();
            q_last.delete();
            m_cnt   = 0;
            m_ready = 1'b1;
            return;
        end
        if (do_pop) begin
            void'(q_data.pop_front());
            void'(q_last.pop_front());
        end
        if (word_valid && m_ready) begin
            if (m_cnt == 0) m_ord = word_order;
            m_words[m_cnt] = word_in;
            m_cnt++;
            if (m_cnt == WPB || word_last) begin
                blk = '0;
                for (int j = 0; j < WPB; j++) begin
                    w = (j < m_cnt) ? m_words[j] : '0;
                    if (!m_ord) blk = (blk << WORD_W) | BLOCK_W'(w);
                    else        blk = blk | (BLOCK_W'(w) << (j * WORD_W));
                end
                q_data.push_back(blk);
                q_last.push_back(word_last);
                m_cnt = 0;
            end
        end
        m_ready = (q_data.size() < DEPTH);
    endtask

    task automatic tick();
        @(posedge tb_clk);
        if (!rst) model_edge();
        #1;
    endtask

    task automatic drive(input logic v, input logic [WORD_W-1:0] w, input logic last,
                         input logic ord, input logic br, input logic sc);
        word_valid  = v;
        word_in     = w;
        word_last   = last;
        word_order  = ord;
        block_ready = br;
        sclr        = sc;
    endtask

    task automatic send(input logic [WORD_W-1:0] w, input logic last,
                        input logic ord, input logic br);
        drive(1'b1, w, last, ord, br, 1'b0);
        tick();
    endtask

    task automatic idle(input logic br);
        drive(1'b0, '0, 1'b0, 1'b0, br, 1'b0);
        tick();
    endtask

    // Compare every DUT output against the model on each falling edge
    always @(negedge tb_clk) begin
        check("word_ready", BLOCK_W'(word_ready), BLOCK_W'(m_ready));
        check("level", BLOCK_W'(level), BLOCK_W'(q_data.size()));
        check("words_held", BLOCK_W'(words_held), BLOCK_W'(m_cnt));
        check("block_valid", BLOCK_W'(block_valid), BLOCK_W'(q_data.size() != 0));
        if (q_data.size() != 0) begin
            check("block_out", block_out, q_data[0]);
            check("block_last", BLOCK_W'(block_last), BLOCK_W'(q_last[0]));
        end
    end

    logic [WORD_W-1:0] tw[4];

    initial begin
        tw[0] = 32'habcd52c2; tw[1] = 32'hf9c6f303;
        tw[2] = 32'h030f8303; tw[3] = 32'h1ab61040;
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge tb_clk);
        #1;
        check("rst_block_out", block_out, '0);
        check("rst_word_ready", BLOCK_W'(word_ready), '0);
        rst = 1'b0;
        tick();
        check("ready_after_release", BLOCK_W'(word_ready), 1);

        // order 0, full block
        for (int i = 0; i < 4; i++) send(tw[i], 1'b0, 1'b0, 1'b0);
        check("t1_valid", BLOCK_W'(block_valid), 1);
        check("t1_block", block_out, 128'habcd52c2f9c6f303030f83031ab61040);
        check("t1_last", BLOCK_W'(block_last), 0);
        check("t1_level", BLOCK_W'(level), 1);
        idle(1'b1);
        idle(1'b0);

        // order 1 latched at word 0, toggled afterwards
        send(tw[0], 1'b0, 1'b1, 1'b0);
        for (int i = 1; i < 4; i++) send(tw[i], 1'b0, 1'b0, 1'b0);
        check("t2_block", block_out, 128'h1ab61040030f8303f9c6f303abcd52c2);
        idle(1'b1);
        idle(1'b0);

        // short block closed by word_last
        send(tw[0], 1'b0, 1'b0, 1'b0);
        send(tw[1], 1'b1, 1'b0, 1'b0);
        check("t3_block", block_out, 128'habcd52c2f9c6f3030000000000000000);
        check("t3_last", BLOCK_W'(block_last), 1);
        check("t3_held", BLOCK_W'(words_held), 0);
        idle(1'b1);
        idle(1'b0);

        // fill to full, refused word, single pop
        for (int i = 0; i < 4; i++) send(tw[i], 1'b0, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) send(WORD_W'(32'h11111111 * i), 1'b0, 1'b0, 1'b0);
        check("t4_level_full", BLOCK_W'(level), 2);
        check("t4_ready_full", BLOCK_W'(word_ready), 0);
        check("t4_head_first", block_out, 128'habcd52c2f9c6f303030f83031ab61040);
        send(32'hdeadbeef, 1'b0, 1'b0, 1'b0);
        send(32'hdeadbeef, 1'b0, 1'b0, 1'b0);
        check("t4_refused_held", BLOCK_W'(words_held), 0);
        check("t4_refused_level", BLOCK_W'(level), 2);
        idle(1'b1);
        check("t4_level_pop", BLOCK_W'(level), 1);
        check("t4_ready_pop", BLOCK_W'(word_ready), 1);
        check("t4_head_second", block_out, 128'h11111111222222223333333344444444);
        idle(1'b1);
        idle(1'b0);

        // streaming with constant block_ready
        for (int i = 0; i < 12; i++) begin
            send($urandom, 1'b0, 1'($urandom_range(0, 1)), 1'b1);
            check("t5_level_le1", BLOCK_W'(level <= 1), 1);
            check("t5_no_stall", BLOCK_W'(word_ready), 1);
        end
        idle(1'b1);
        idle(1'b0);

        // async reset mid-block
        send(tw[0], 1'b0, 1'b0, 1'b0);
        send(tw[1], 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        model_reset();
        #1;
        check("t6_rst_ready", BLOCK_W'(word_ready), 0);
        check("t6_rst_valid", BLOCK_W'(block_valid), 0);
        check("t6_rst_held", BLOCK_W'(words_held), 0);
        check("t6_rst_level", BLOCK_W'(level), 0);
        check("t6_rst_block", block_out, '0);
        @(posedge tb_clk);
        #1;
        rst = 1'b0;
        idle(1'b0);

        // sclr with partial block and stored block, while popping
        for (int i = 0; i < 7; i++) send(tw[i % 4], 1'b0, 1'b0, 1'b0);
        drive(1'b1, 32'hcafef00d, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        check("t6_sclr_level", BLOCK_W'(level), 0);
        check("t6_sclr_held", BLOCK_W'(words_held), 0);
        check("t6_sclr_valid", BLOCK_W'(block_valid), 0);
        check("t6_sclr_ready", BLOCK_W'(word_ready), 1);
        for (int i = 0; i < 8; i++) send(tw[i % 4], 1'b0, 1'b0, 1'b0);
        drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        check("t6_sclr_full_level", BLOCK_W'(level), 0);
        for (int i = 0; i < 4; i++) send(tw[3 - i], 1'b0, 1'b0, 1'b0);
        check("t6_fresh_block", block_out, 128'h1ab61040030f8303f9c6f303abcd52c2);
        idle(1'b1);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            drive(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 5) == 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 49) == 0));
            tick();
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
